// File: rtl/casez_enc01_if.sv
// Handshake bundle between a request source and the casez encoder:
// vectors flow in on req_*, codes flow out on code_*.
interface casez_enc01_if;
  logic [7:0] req_vec;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       code_last;
  logic       zero_seen;

  modport master (
    output req_vec, req_valid, code_ready,
    input  req_ready, code, code_valid, code_last, zero_seen
  );

  modport slave (
    input  req_vec, req_valid, code_ready,
    output req_ready, code, code_valid, code_last, zero_seen
  );
endinterface

// File: rtl/casez_enc01_prienc8.sv
// 8-bit priority encoder, bit 7 highest; also flags when exactly one bit is set.
module prienc8 (
  input  logic [7:0] vec_i,
  output logic [2:0] code_o,
  output logic       one_o
);
  always_comb begin
    code_o = 3'd0;
    casez (vec_i)
      8'b1???????: code_o = 3'd7;
      8'b01??????: code_o = 3'd6;
      8'b001?????: code_o = 3'd5;
      8'b0001????: code_o = 3'd4;
      8'b00001???: code_o = 3'd3;
      8'b000001??: code_o = 3'd2;
      8'b0000001?: code_o = 3'd1;
      8'b00000001: code_o = 3'd0;
      default:     code_o = 3'd0;
    endcase
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_o = (vec_i != 8'd0) && ((vec_i & (vec_i - 8'd1)) == 8'd0);
endmodule

// File: rtl/casez_enc01.sv
// Serializes a request vector into descending bit-index codes, one per
// accepted transfer, then returns to IDLE for the next vector.
module casez_enc01 (
  input  logic          clk,
  input  logic          rst,
  casez_enc01_if.slave  bus
);
  localparam logic IDLE_ENC = 1'b0;
  localparam logic BUSY_ENC = 1'b1;

  typedef enum logic {
    IDLE = IDLE_ENC,
    BUSY = BUSY_ENC
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic       zeroSeen_q, zeroSeen_d;
  logic [2:0] code;
  logic       isLast;

  prienc8 u_prienc (
    .vec_i  (pending_q),
    .code_o (code),
    .one_o  (isLast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 8'd0;
      zeroSeen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zeroSeen_q <= zeroSeen_d;
    end
  end

  // Requests seen while BUSY are dropped; code_ready in IDLE is ignored.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    zeroSeen_d     = 1'b0;
    bus.req_ready  = 1'b0;
    bus.code_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          pending_d = bus.req_vec;
          if (bus.req_vec == 8'd0) zeroSeen_d = 1'b1;
          else                     state_d    = BUSY;
        end
      end
      BUSY: begin
        bus.code_valid = 1'b1;
        if (bus.code_ready) begin
          pending_d = pending_q & ~(8'd1 << code);
          if (isLast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.code      = code;
  assign bus.code_last = isLast;
  assign bus.zero_seen = zeroSeen_q;
endmodule

// File: doc/casez_enc01.md
CASEZ_ENC01 -- requirements
Module: casez_enc01

Interface
REQ-001 Parameters: none; vector width fixed at 8, code width fixed at 3.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_vec  input  8  request vector to be serialized into codes.
REQ-005 req_valid  input  1  req_vec is valid this cycle.
REQ-006 req_ready  output  1  block can accept a new vector.
REQ-007 code  output  3  index of the highest set pending bit.
REQ-008 code_valid  output  1  code is valid this cycle.
REQ-009 code_ready  input  1  downstream accepts code this cycle.
REQ-010 code_last  output  1  current code is the final one for the loaded vector.
REQ-011 zero_seen  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-013 In IDLE, req_ready SHALL be 1 and code_valid SHALL be 0; in BUSY, req_ready SHALL be 0 and code_valid SHALL be 1.
REQ-014 A vector is accepted on a cycle with req_valid=1 and req_ready=1; the 8-bit pending register SHALL load req_vec on that edge.
REQ-015 Accepting a non-zero vector: IDLE->BUSY; code_valid is first 1 in the next cycle (latency 1).
REQ-016 Accepting 8'h00: state SHALL remain IDLE; zero_seen SHALL be 1 for exactly the next cycle; no code is emitted.
REQ-017 code SHALL be the highest-priority set bit of pending, bit 7 highest, decoded with casez don't-care patterns (1???????->7 ... 00000001->0).
REQ-018 code and code_last SHALL be driven combinationally from pending and SHALL be stable while code_valid=1 and code_ready=0.
REQ-019 code_last SHALL be 1 when exactly one bit of pending is set.
REQ-020 On code_valid=1 and code_ready=1, the bit of pending selected by code SHALL be cleared.
REQ-021 If that transfer has code_last=1, the FSM SHALL go BUSY->IDLE, and req_ready SHALL be 1 in the next cycle.
REQ-022 A vector with k set bits SHALL produce exactly k codes, in strictly descending order, with code_last=1 only on the k-th.
REQ-023 req_valid while in BUSY SHALL be ignored; no buffering or back-pressure state is kept.
REQ-024 code_ready while in IDLE SHALL have no effect.

Reset
REQ-025 When rst=1 at a clock edge, the FSM SHALL enter IDLE and pending SHALL become 8'h00; this takes priority over any handshake in the same cycle.
REQ-026 One cycle after reset: req_ready=1, code_valid=0, code=3'd0, code_last=0, zero_seen=0.
REQ-027 Reset asserted mid-sequence SHALL discard all remaining pending bits without emitting them.

Structure
REQ-028 No shared package; the IDLE/BUSY encodings SHALL be module-local localparams.
REQ-029 The priority lookup SHALL be a combinational sub-module prienc8 (8-bit in, 3-bit code, one-hot-count-is-one flag) built around a casez.
REQ-030 The FSM and pending register SHALL reside in casez_enc01.

Verification
REQ-031 Load 8'b1010_0100 with code_ready held at 1 -> codes 7, 5, 2 on consecutive cycles; code_last=1 only with 2; req_ready=1 on the following cycle.
REQ-032 Load 8'h01 -> a single code 0 with code_last=1; back in IDLE after one transfer.
REQ-033 Load 8'h00 -> zero_seen=1 for one cycle; code_valid never asserts; req_ready stays 1.
REQ-034 Load 8'hFF with code_ready toggling 1,0,1,0,... -> codes 7..0 in order; code stable through each stall; 8 transfers total.
REQ-035 Load 8'b0110_0000, then assert rst after the first transfer (code 6) -> code 5 is never emitted; IDLE with pending=8'h00 the next cycle.
REQ-036 Assert req_valid with 8'h0F while BUSY on 8'h80 -> 8'h0F ignored; only code 7 is emitted.
